pipelined_addsub: RTL and testbench

- Parametrised successor to the team's single-cycle wide adder. Adds or subtracts two W-bit operands with carry/borrow-in.
- The carry chain is split into S registered chunks, so wide adders (256+ bits) close timing at full clock rate.
- Streaming valid/ready interface with backpressure. Throughput is one operation per cycle; latency is S cycles.
- Sits between operand-fetch logic and the result writeback in the arithmetic datapath.

---
 rtl/addsub_pkg.sv | 18 +
 rtl/addsub_chunk.sv | 33 +++
 rtl/pipelined_addsub.sv | 137 +++++++++++++
 tb/tb_pipelined_addsub.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: mode encoding,
// chunk-width helper and the operand-width divisibility check.
package addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Width of one carry chunk when W bits are split across S stages.
    function automatic int chunk_width(input int w, input int s);
        return w / s;
    endfunction

    // The carry chain can only be split evenly; anything else is a build error.
    function automatic bit width_ok(input int w, input int s);
        return (s > 0) && ((w % s) == 0);
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// One registered C-bit slice of the carry chain. The operand for subtraction
// arrives already inverted, so this slice is always a plain add.
module addsub_chunk
    import addsub_pkg::*;
#(
    parameter int C = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [C-1:0] a_chunk,
    input  logic [C-1:0] b_chunk,
    input  logic         carry_in,
    output logic [C-1:0] sum_chunk,
    output logic         carry_out
);

    logic [C:0] total;

    assign total = {1'b0, a_chunk} + {1'b0, b_chunk} + {{C{1'b0}}, carry_in};

    // Register the slice result and its carry; hold while the pipe is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_chunk <= '0;
            carry_out <= 1'b0;
        end else if (en) begin
            sum_chunk <= total[C-1:0];
            carry_out <= total[C];
        end
    end

endmodule

// File: rtl/pipelined_addsub.sv
// W-bit add/subtract with carry/borrow-in, carry chain split into S registered
// chunks. Operand chunks are skewed in so each stage sees its slice together
// with the previous stage's carry, then the result chunks are de-skewed so the
// whole word leaves aligned. Streaming valid/ready with full-pipe stall.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int W = 256,
    parameter int S = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int C = chunk_width(W, S);

    if (!width_ok(W, S)) begin : g_bad_width
        $error("pipelined_addsub: W must be a multiple of S");
    end

    logic         advance;
    logic [W-1:0] b_eff;
    logic         cin_eff;
    logic [S-1:0] vld_p;
    logic [S-1:0] mode_p;
    logic [S-1:0] carry;

    // The whole pipe moves together; stalling anywhere stalls everything.
    assign advance   = ~out_valid | out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_p[S-1];

    // Subtraction is a + ~b + ~cin; the final carry is inverted into a borrow.
    always_comb begin
        b_eff   = b;
        cin_eff = cin;
        if (sub == MODE_SUB) begin
            b_eff   = ~b;
            cin_eff = ~cin;
        end
    end

    // Valid and mode travel in lockstep with the beat through all S stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p  <= '0;
            mode_p <= '0;
        end else if (advance) begin
            vld_p[0]  <= in_valid;
            mode_p[0] <= sub;
            for (int i = 1; i < S; i++) begin
                vld_p[i]  <= vld_p[i-1];
                mode_p[i] <= mode_p[i-1];
            end
        end
    end

    assign cout = carry[S-1] ^ (mode_p[S-1] == MODE_SUB);

    for (genvar k = 0; k < S; k++) begin : g_stage
        logic [C-1:0] a_in;
        logic [C-1:0] b_in;
        logic         cy_in;
        logic [C-1:0] chunk_q;

        if (k == 0) begin : g_first
            assign a_in  = a[C-1:0];
            assign b_in  = b_eff[C-1:0];
            assign cy_in = cin_eff;
        end else begin : g_skew
            logic [C-1:0] a_sk [k];
            logic [C-1:0] b_sk [k];

            // Delay this chunk's operands k cycles so they meet the carry of the same beat.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < k; i++) begin
                        a_sk[i] <= '0;
                        b_sk[i] <= '0;
                    end
                end else if (advance) begin
                    a_sk[0] <= a[k*C +: C];
                    b_sk[0] <= b_eff[k*C +: C];
                    for (int i = 1; i < k; i++) begin
                        a_sk[i] <= a_sk[i-1];
                        b_sk[i] <= b_sk[i-1];
                    end
                end
            end

            assign a_in  = a_sk[k-1];
            assign b_in  = b_sk[k-1];
            assign cy_in = carry[k-1];
        end

        addsub_chunk #(.C(C)) u_chunk (
            .clk       (clk),
            .rst       (rst),
            .en        (advance),
            .a_chunk   (a_in),
            .b_chunk   (b_in),
            .carry_in  (cy_in),
            .sum_chunk (chunk_q),
            .carry_out (carry[k])
        );

        if (k == S-1) begin : g_last
            assign sum[k*C +: C] = chunk_q;
        end else begin : g_deskew
            localparam int D = S - 1 - k;
            logic [C-1:0] dsk [D];

            // Hold early result chunks until the top chunk of the same beat is done.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < D; i++) dsk[i] <= '0;
                end else if (advance) begin
                    dsk[0] <= chunk_q;
                    for (int i = 1; i < D; i++) dsk[i] <= dsk[i-1];
                end
            end

            assign sum[k*C +: C] = dsk[D-1];
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub: vector table for single-beat arithmetic
// and latency, plus hand-written streaming, backpressure, mixed-mode, reset and
// W=8/S=1 sequences.
module tb_pipelined_addsub;

    localparam int W = 256;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, sum;
    logic         cin, sub, cout;

    logic         d8_in_valid, d8_in_ready, d8_out_valid, d8_out_ready;
    logic [7:0]   d8_a, d8_b, d8_sum;
    logic         d8_cin, d8_sub, d8_cout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipelined_addsub #(.W(W), .S(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
    );

    pipelined_addsub #(.W(8), .S(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(d8_in_valid), .in_ready(d8_in_ready),
        .a(d8_a), .b(d8_b), .cin(d8_cin), .sub(d8_sub),
        .out_valid(d8_out_valid), .out_ready(d8_out_ready), .sum(d8_sum), .cout(d8_cout)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
    } beat_t;

    beat_t        send_q[$];
    logic [W:0]   exp_q[$];

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference arithmetic on a 257-bit word: top bit is carry (add) or borrow (sub).
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic s);
        logic [W:0] r;
        if (s) r = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, ci};
        else   r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        return r;
    endfunction

    task automatic apply_vec(input vec_t v, input int idx);
        a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (S - 2) step();
        check($sformatf("tbl%0d_early_valid", idx), {{W{1'b0}}, out_valid}, '0);
        step();
        check($sformatf("tbl%0d_valid", idx), {{W{1'b0}}, out_valid}, {{W{1'b0}}, 1'b1});
        check($sformatf("tbl%0d_sum", idx), {1'b0, sum}, {1'b0, v.sum});
        check($sformatf("tbl%0d_cout", idx), {{W{1'b0}}, cout}, {{W{1'b0}}, v.cout});
        step();
    endtask

    // Pushes send_q through the DUT, scoring every consumed result against the model.
    task automatic run_traffic(input string tag, input int stall_len, output int cycles);
        int         cyc = 0;
        int         stall_left = 0;
        bit         stall_done = 0;
        logic [W:0] held = '0;
        logic [W:0] got;
        cycles = 0;
        while ((send_q.size() > 0 || exp_q.size() > 0) && cyc < 200) begin
            if (send_q.size() > 0) begin
                a = send_q[0].a; b = send_q[0].b; cin = send_q[0].cin; sub = send_q[0].sub;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (stall_len > 0 && !stall_done && out_valid) begin
                stall_done = 1;
                stall_left = stall_len;
            end
            out_ready = (stall_left == 0);
            #1;
            got = {cout, sum};
            if (stall_left > 0) begin
                check({tag, "_in_ready_stall"}, {{W{1'b0}}, in_ready}, '0);
                if (stall_left < stall_len) check({tag, "_hold"}, got, held);
                held = got;
                stall_left--;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(send_q[0].a, send_q[0].b, send_q[0].cin, send_q[0].sub));
                void'(send_q.pop_front());
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_extra_result"}, got, '1);
                end else begin
                    check({tag, "_result"}, got, exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (cyc >= 200) check({tag, "_timeout"}, 257'd1, 257'd0);
        cycles = cyc;
        repeat (S + 1) step();
        check({tag, "_drained"}, {{W{1'b0}}, out_valid}, '0);
    endtask

    vec_t       vecs[8];
    logic [W-1:0] x;
    int         cyc_n;
    bit         any_valid;

    initial begin
        x = 256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;
        vecs[0] = '{a: '1, b: '0, cin: 1'b1, sub: 1'b0, sum: '0, cout: 1'b1};
        vecs[1] = '{a: 256'd5, b: 256'd7, cin: 1'b0, sub: 1'b1, sum: {{255{1'b1}}, 1'b0}, cout: 1'b1};
        vecs[2] = '{a: 256'd7, b: 256'd5, cin: 1'b1, sub: 1'b1, sum: 256'd1, cout: 1'b0};
        vecs[3] = '{a: {192'd0, {64{1'b1}}}, b: 256'd1, cin: 1'b0, sub: 1'b0, sum: (256'd1 << 64), cout: 1'b0};
        vecs[4] = '{a: '0, b: '0, cin: 1'b1, sub: 1'b1, sum: '1, cout: 1'b1};
        vecs[5] = '{a: (256'd1 << 192), b: 256'd1, cin: 1'b0, sub: 1'b1, sum: {64'd0, {192{1'b1}}}, cout: 1'b0};
        vecs[6] = '{a: x, b: x, cin: 1'b0, sub: 1'b1, sum: '0, cout: 1'b0};
        vecs[7] = '{a: {1'b1, 255'd0}, b: {1'b1, 255'd0}, cin: 1'b0, sub: 1'b0, sum: '0, cout: 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        d8_in_valid = 1'b0; d8_out_ready = 1'b1;
        d8_a = '0; d8_b = '0; d8_cin = 1'b0; d8_sub = 1'b0;
        repeat (3) step();
        check("rst_out_valid", {{W{1'b0}}, out_valid}, '0);
        check("rst_sum", {1'b0, sum}, '0);
        check("rst_cout", {{W{1'b0}}, cout}, '0);
        check("rst_in_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) apply_vec(vecs[i], i);

        // Eight back-to-back beats: results must come out on eight consecutive cycles.
        for (int i = 0; i < 8; i++)
            send_q.push_back('{a: W'(i), b: {192'd0, {64{1'b1}}}, cin: 1'b0, sub: 1'b0});
        run_traffic("stream", 0, cyc_n);
        check("stream_cycles", W'(cyc_n), W'(12));

        // Six beats with a three-cycle output stall.
        for (int i = 0; i < 6; i++)
            send_q.push_back('{a: x ^ W'(i * 3), b: ~x + W'(i), cin: i[0], sub: 1'b0});
        run_traffic("bp", 3, cyc_n);

        // Alternating add and subtract beats.
        for (int i = 0; i < 6; i++)
            send_q.push_back('{a: (x << i), b: (x >> i), cin: i[1], sub: i[0]});
        run_traffic("mixed", 0, cyc_n);

        // Reset with three beats in flight, in_valid held high during the reset edge.
        for (int i = 0; i < 3; i++) begin
            a = '1; b = W'(i + 1); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        check("midrst_out_valid", {{W{1'b0}}, out_valid}, '0);
        check("midrst_sum", {1'b0, sum}, '0);
        check("midrst_cout", {{W{1'b0}}, cout}, '0);
        any_valid = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) any_valid = 1;
        end
        check("midrst_no_ghost", {{W{1'b0}}, any_valid}, '0);
        apply_vec(vecs[1], 100);

        // Degenerate single-stage build: one registered add, latency 1.
        d8_a = 8'd200; d8_b = 8'd100; d8_cin = 1'b0; d8_sub = 1'b0; d8_in_valid = 1'b1;
        step();
        d8_in_valid = 1'b0;
        check("s1_valid", {{W{1'b0}}, d8_out_valid}, {{W{1'b0}}, 1'b1});
        check("s1_sum", {{(W-7){1'b0}}, d8_sum}, {{(W-7){1'b0}}, 8'd44});
        check("s1_cout", {{W{1'b0}}, d8_cout}, {{W{1'b0}}, 1'b1});
        d8_a = 8'd100; d8_b = 8'd200; d8_cin = 1'b1; d8_sub = 1'b1; d8_in_valid = 1'b1;
        step();
        d8_in_valid = 1'b0;
        check("s1_sub_sum", {{(W-7){1'b0}}, d8_sum}, {{(W-7){1'b0}}, 8'd155});
        check("s1_sub_cout", {{W{1'b0}}, d8_cout}, {{W{1'b0}}, 1'b1});
        step();
        check("s1_idle", {{W{1'b0}}, d8_out_valid}, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
